seq_divider: RTL and testbench

Multi-cycle restoring divider, the inverse of the team's 6x7 array multiplier. Divides a 13-bit dividend by a 6-bit divisor, producing a 13-bit quotient and 6-bit remainder, one quotient bit per clock. A start/busy/done handshake lets the datapath check multiplier results (C / A = B) or perform standalone division. Unsigned or two's-complement operation is selected per operation by `t`, matching the multiplier's `t` convention.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 169 ++++++++++++++++
 tb/tb_seq_divider.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the sequential restoring divider.
package div_pkg;

  localparam int N_W_DEFAULT   = 13;
  localparam int D_W_DEFAULT   = 6;
  localparam int CNT_W_DEFAULT = $clog2(N_W_DEFAULT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int D_W = 6
) (
  input  logic [D_W-1:0] rem,
  input  logic           bit_in,
  input  logic [D_W-1:0] dvs,
  output logic [D_W-1:0] rem_nx,
  output logic           q_bit
);

  logic        [D_W:0]   shifted;
  logic signed [D_W+1:0] diff;
  logic                  unused_diff;

  // The shifted value never exceeds 2*dvs-1, so both kept results fit back into D_W bits.
  always_comb begin
    shifted = {rem, bit_in};
    diff    = $signed({1'b0, shifted}) - $signed({2'b00, dvs});
    q_bit   = ~diff[D_W+1];
    rem_nx  = q_bit ? diff[D_W-1:0] : shifted[D_W-1:0];
  end

  assign unused_diff = diff[D_W];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional two's-complement mode is built when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider
  import div_pkg::*;
#(
  parameter int N_W = N_W_DEFAULT,
  parameter int D_W = D_W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           t,
  input  logic [N_W-1:0] A,
  input  logic [D_W-1:0] B,
  output logic           busy,
  output logic           done,
  output logic [N_W-1:0] Q,
  output logic [D_W-1:0] R,
  output logic           dbz,
  output logic           ovf
);

  localparam int CNT_W = $clog2(N_W + 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             b_zero;

  logic [N_W-1:0]   work;
  logic [D_W-1:0]   rem;
  logic [D_W-1:0]   dvs;
  logic             dbz_pend;

  logic [N_W-1:0]   a_mag;
  logic [D_W-1:0]   b_mag;
  logic [N_W-1:0]   fix_q;
  logic [D_W-1:0]   fix_r;
  logic [D_W-1:0]   rem_nx;
  logic             q_bit;

  assign accept = (state == IDLE) && start;
  assign b_zero = (B == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic signed [N_W-1:0] A_MIN = {1'b1, {(N_W-1){1'b0}}};

  function automatic logic [N_W-1:0] neg_n(input logic [N_W-1:0] x);
    return ~x + N_W'(1);
  endfunction

  function automatic logic [D_W-1:0] neg_d(input logic [D_W-1:0] x);
    return ~x + D_W'(1);
  endfunction

  logic a_neg;
  logic b_neg;
  logic ovf_det;
  logic q_neg;
  logic r_neg;
  logic ovf_pend;

  // Magnitude of the most negative dividend is 2^(N_W-1), still representable unsigned.
  assign a_neg   = t & A[N_W-1];
  assign b_neg   = t & B[D_W-1];
  assign ovf_det = t && (A == A_MIN) && (B == '1);
  assign a_mag   = a_neg ? neg_n(A) : A;
  assign b_mag   = b_neg ? neg_d(B) : B;
  assign fix_q   = q_neg ? neg_n(work) : work;
  assign fix_r   = (r_neg && (rem != '0)) ? neg_d(rem) : rem;

  always_ff @(posedge clk) begin
    if (accept) begin
      q_neg    <= !b_zero && (a_neg ^ b_neg);
      r_neg    <= !b_zero && a_neg;
      ovf_pend <= ovf_det;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == FIX) begin
      ovf <= ovf_pend;
    end
  end
`else
  logic unused_t;

  assign unused_t = t;
  assign a_mag    = A;
  assign b_mag    = B;
  assign fix_q    = work;
  assign fix_r    = rem;
  assign ovf      = 1'b0;
`endif

  div_step #(
    .D_W (D_W)
  ) u_step (
    .rem    (rem),
    .bit_in (work[N_W-1]),
    .dvs    (dvs),
    .rem_nx (rem_nx),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= CNT_W'(N_W);
      end else if (state == CALC) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = b_zero ? FIX : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Dividend register doubles as the quotient shift register; divide-by-zero preloads the answer.
  always_ff @(posedge clk) begin
    if (accept) begin
      dbz_pend <= b_zero;
      dvs      <= b_mag;
      if (b_zero) begin
        work <= '1;
        rem  <= A[D_W-1:0];
      end else begin
        work <= a_mag;
        rem  <= '0;
      end
    end else if (state == CALC) begin
      work <= {work[N_W-2:0], q_bit};
      rem  <= rem_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      Q    <= '0;
      R    <= '0;
      dbz  <= 1'b0;
    end else begin
      busy <= (state == CALC);
      done <= (state == FIX);
      if (state == FIX) begin
        Q   <= fix_q;
        R   <= fix_r;
        dbz <= dbz_pend;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed table, handshake corner cases and random ops against an arithmetic model.
module tb_seq_divider;

  localparam int N_W = 13;
  localparam int D_W = 6;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam bit SG = 1'b1;
`else
  localparam bit SG = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           start;
  logic           t;
  logic [N_W-1:0] A;
  logic [D_W-1:0] B;
  logic           busy;
  logic           done;
  logic [N_W-1:0] Q;
  logic [D_W-1:0] R;
  logic           dbz;
  logic           ovf;

  int n_vec = 0;
  int n_mis = 0;

  logic [N_W-1:0] prev_q;
  logic [D_W-1:0] prev_r;

  seq_divider dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .t     (t),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Q     (Q),
    .R     (R),
    .dbz   (dbz),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] a;
    logic [5:0]  b;
    logic        t;
    logic [12:0] qs;
    logic [5:0]  rs;
    logic        os;
    logic [12:0] qu;
    logic [5:0]  ru;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [12:0] q;
    logic [5:0]  r;
    logic        dz;
    logic        ov;
  } res_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [12:0] a, input logic [5:0] b, input logic tt);
    res_t m;
    int   sa;
    int   sb;
    int   q;
    int   r;
    m.dz = 1'b0;
    m.ov = 1'b0;
    if (b == 6'd0) begin
      m.q  = 13'h1FFF;
      m.r  = a[5:0];
      m.dz = 1'b1;
    end else if (SG && tt) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      m.q  = 13'(q);
      m.r  = 6'(r);
      m.ov = (sa == -4096) && (sb == -1);
    end else begin
      q  = int'(a) / int'(b);
      r  = int'(a) % int'(b);
      m.q = 13'(q);
      m.r = 6'(r);
    end
    return m;
  endfunction

  // Starts one operation and follows it edge by edge until done (bounded).
  task automatic run_op(input logic [12:0] a, input logic [5:0] b, input logic tt,
                        input logic [12:0] eq, input logic [5:0] er,
                        input logic ed, input logic eo, input bit noise);
    int exp_lat;
    bit seen;
    exp_lat = (b == 6'd0) ? 1 : N_W + 1;
    A = a; B = b; t = tt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_fall", 32'(done), 32'(0));
    chk("busy_e0", 32'(busy), 32'(0));
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (noise && k >= 2 && k <= 8) begin
        start = 1'b1;
        A = 13'($urandom);
        B = 6'($urandom);
        t = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        chk("latency", 32'(k), 32'(exp_lat));
      end else begin
        chk("busy", 32'(busy), 32'(b != 6'd0));
        chk("hold_q", 32'(Q), 32'(prev_q));
        chk("hold_r", 32'(R), 32'(prev_r));
      end
    end
    start = 1'b0;
    if (!seen) chk("timeout", 32'(0), 32'(1));
    chk("busy_done", 32'(busy), 32'(0));
    chk("q", 32'(Q), 32'(eq));
    chk("r", 32'(R), 32'(er));
    chk("dbz", 32'(dbz), 32'(ed));
    chk("ovf", 32'(ovf), 32'(eo));
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    res_t        m;
    logic [12:0] ra;
    logic [5:0]  rb;
    logic        rt;
    bit          stray;

    //              a        b      t   qs        rs     os    qu        ru     dz
    tbl[0]  = '{13'h0FFF, 6'h3F, 1'b0, 13'h0041, 6'h00, 1'b0, 13'h0041, 6'h00, 1'b0};
    tbl[1]  = '{13'h1F9C, 6'h07, 1'b1, 13'h1FF2, 6'h3E, 1'b0, 13'h0484, 6'h00, 1'b0};
    tbl[2]  = '{13'h1000, 6'h3F, 1'b1, 13'h1000, 6'h00, 1'b1, 13'h0041, 6'h01, 1'b0};
    tbl[3]  = '{13'h1000, 6'h3F, 1'b0, 13'h0041, 6'h01, 1'b0, 13'h0041, 6'h01, 1'b0};
    tbl[4]  = '{13'h0005, 6'h00, 1'b0, 13'h1FFF, 6'h05, 1'b0, 13'h1FFF, 6'h05, 1'b1};
    tbl[5]  = '{13'h0064, 6'h07, 1'b1, 13'h000E, 6'h02, 1'b0, 13'h000E, 6'h02, 1'b0};
    tbl[6]  = '{13'h0064, 6'h39, 1'b1, 13'h1FF2, 6'h02, 1'b0, 13'h0001, 6'h2B, 1'b0};
    tbl[7]  = '{13'h1F9C, 6'h39, 1'b1, 13'h000E, 6'h3E, 1'b0, 13'h008D, 6'h37, 1'b0};
    tbl[8]  = '{13'h1FFF, 6'h01, 1'b0, 13'h1FFF, 6'h00, 1'b0, 13'h1FFF, 6'h00, 1'b0};
    tbl[9]  = '{13'h0003, 6'h3F, 1'b0, 13'h0000, 6'h03, 1'b0, 13'h0000, 6'h03, 1'b0};
    tbl[10] = '{13'h1234, 6'h00, 1'b1, 13'h1FFF, 6'h34, 1'b0, 13'h1FFF, 6'h34, 1'b1};
    tbl[11] = '{13'h0000, 6'h05, 1'b1, 13'h0000, 6'h00, 1'b0, 13'h0000, 6'h00, 1'b0};
    tbl[12] = '{13'h1FFF, 6'h3F, 1'b1, 13'h0001, 6'h00, 1'b0, 13'h0082, 6'h01, 1'b0};
    tbl[13] = '{13'h1000, 6'h01, 1'b1, 13'h1000, 6'h00, 1'b0, 13'h1000, 6'h00, 1'b0};
    tbl[14] = '{13'h1000, 6'h20, 1'b1, 13'h0080, 6'h00, 1'b0, 13'h0080, 6'h00, 1'b0};
    tbl[15] = '{13'h0FFF, 6'h20, 1'b1, 13'h1F81, 6'h1F, 1'b0, 13'h007F, 6'h1F, 1'b0};

    rst = 1'b1; start = 1'b0; t = 1'b0; A = '0; B = '0;
    prev_q = '0; prev_r = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_q", 32'(Q), 32'(0));
    chk("rst_r", 32'(R), 32'(0));
    chk("rst_dbz", 32'(dbz), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table, issued back to back so each start lands in the previous done cycle.
    for (int i = 0; i < 16; i++) begin
      if (SG && tbl[i].t)
        run_op(tbl[i].a, tbl[i].b, tbl[i].t, tbl[i].qs, tbl[i].rs, tbl[i].dz, tbl[i].os, 1'b0);
      else
        run_op(tbl[i].a, tbl[i].b, tbl[i].t, tbl[i].qu, tbl[i].ru, tbl[i].dz, 1'b0, 1'b0);
    end

    // Extra start pulses with other operands while busy must not disturb the operation.
    run_op(13'h0FFF, 6'h3F, 1'b0, 13'h0041, 6'h00, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_noise", 32'(busy), 32'(0));

    // Reset at edge 7 of an operation: outputs clear at once and nothing completes.
    A = 13'h0FFF; B = 6'h07; t = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_q", 32'(Q), 32'(0));
    chk("arst_r", 32'(R), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_dbz", 32'(dbz), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done || busy) stray = 1'b1;
    end
    chk("no_done_after_rst", 32'(stray), 32'(0));
    prev_q = '0;
    prev_r = '0;
    run_op(13'h0FFF, 6'h07, 1'b0, 13'h0249, 6'h00, 1'b0, 1'b0, 1'b0);

    // Random operations, with divide-by-zero and the overflow operands mixed in.
    for (int i = 0; i < 60; i++) begin
      ra = 13'($urandom);
      rb = 6'($urandom);
      rt = 1'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 6'd0;
        1: begin ra = 13'h1000; rb = 6'h3F; end
        2: rb = 6'h01;
        default: ;
      endcase
      m = model(ra, rb, rt);
      run_op(ra, rb, rt, m.q, m.r, m.dz, m.ov, (i % 7) == 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
